// File: rtl/spi_mul_unit_pkg.sv
// Shared ISA types for the SPI multiply slave: opcodes, packet layouts, status width.
// Decode helper used when an Rx packet is turned into an operation.
package spi_mul_unit_pkg;

    localparam int REGISTER_SIZE   = 16;
    localparam int MUL_STATUS_BITS = 2;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHU  = 3'd2,
        MAC    = 3'd3,
        ACCCLR = 3'd4
    } Instruction;

    localparam int OP_BITS = $bits(Instruction);

    typedef struct packed {
        logic [REGISTER_SIZE-1:0] op_2;
        logic [REGISTER_SIZE-1:0] op_1;
        Instruction               op_code;
    } MulRxPacket;

    typedef struct packed {
        logic                     ovf;
        logic                     err;
        logic [REGISTER_SIZE-1:0] result;
    } MulTxPacket;

    // Accumulator opcodes only exist when the accumulator is built.
    function automatic logic op_valid(input logic [OP_BITS-1:0] code, input logic acc_en);
        logic valid_s;
        case (code)
            MUL, MULH, MULHU: valid_s = 1'b1;
            MAC, ACCCLR:      valid_s = acc_en;
            default:          valid_s = 1'b0;
        endcase
        return valid_s;
    endfunction

endpackage

// File: rtl/spi_if.sv
// Shared SPI bus: one mosi line, one active-low nss and one miso line per slave.
// miso is a net so that each slave can drive only its own bit.
interface Spi #(
    parameter int NUM_SLAVES = 2
);
    logic                  mosi;
    logic [NUM_SLAVES-1:0] nss;
    wire  [NUM_SLAVES-1:0] miso;

    modport SlaveSpi  (input mosi, input nss, output miso);
    modport MasterSpi (output mosi, output nss, input miso);
endinterface

// File: rtl/spi_mul_unit_seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier: W clocks per product, done is a 1-clock pulse.
// The first partial product is folded into the load so p is final when done rises.
module seq_multiplier #(
    parameter int W = 16
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    logic [W-1:0]   a_r;
    logic [2*W-1:0] p_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;

    function automatic logic [2*W-1:0] step(input logic [2*W-1:0] acc, input logic [W-1:0] m);
        logic [W:0] sum_s;
        sum_s = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : {(W + 1){1'b0}});
        return {sum_s, acc[W-1:1]};
    endfunction

    // Load-and-first-step on start, then one add/shift per clock until W steps are done.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            a_r    <= '0;
            p_r    <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                p_r <= step(p_r, a_r);
                if (cnt_r == LAST_STEP) begin
                    cnt_r  <= '0;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else if (start) begin
                a_r    <= a;
                p_r    <= step({{W{1'b0}}, b}, a);
                cnt_r  <= CW'(1);
                busy_r <= 1'b1;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign p    = p_r;

endmodule

// File: rtl/spi_mul_unit.sv
// SPI-slave multiply unit: receives {op_2, op_1, op_code}, runs a sequential multiply,
// returns {ovf, err, result} LSB first.
module spi_mul_unit
    import spi_mul_unit_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int SLAVE_ID = 1,
    parameter int ACC_EN   = 1
) (
    input  logic  i_clock,
    input  logic  i_reset,
    Spi.SlaveSpi  spi
);

    localparam int W       = NUM_BITS;
    localparam int RX_BITS = 2 * W + OP_BITS;
    localparam int TX_BITS = W + MUL_STATUS_BITS;
    localparam int CW      = $clog2(RX_BITS);
    localparam logic [CW-1:0] RX_LAST = CW'(RX_BITS - 1);
    localparam logic [CW-1:0] TX_LAST = CW'(TX_BITS - 1);

    typedef enum logic [2:0] {RECEIVE, RECEIVING, DECODE, OPERATE, SEND, SENDING} state_t;

    state_t               state_r, state_next_s;
    logic [CW-1:0]        cnt_r, cnt_next_s;
    logic [RX_BITS-1:0]   rx_r, rx_next_s;
    logic [TX_BITS-1:0]   tx_r, tx_next_s;
    logic [OP_BITS-1:0]   op_r, op_next_s;
    logic                 neg_r, neg_next_s;
    logic                 nss_q_r;
    logic [W-1:0]         acc_r, acc_next_s;

    logic                 nss_s, mosi_s, nss_rise_s, miso_s;
    logic [OP_BITS-1:0]   op_code_s;
    logic [W-1:0]         op_1_s, op_2_s;
    logic                 mul_start_s, mul_busy_s, mul_done_s;
    logic [W-1:0]         mul_a_s, mul_b_s;
    logic [2*W-1:0]       mul_p_s, prod_s;
    logic [W-1:0]         prod_lo_s, prod_hi_s;
    logic [W:0]           mac_sum_s;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
        return v[W-1] ? ({W{1'b0}} - v) : v;
    endfunction

    assign nss_s      = spi.nss[SLAVE_ID];
    assign mosi_s     = spi.mosi;
    assign nss_rise_s = nss_s & ~nss_q_r;

    assign op_code_s = rx_r[OP_BITS-1:0];
    assign op_1_s    = rx_r[OP_BITS +: W];
    assign op_2_s    = rx_r[OP_BITS + W +: W];

    assign prod_s    = neg_r ? ({(2 * W){1'b0}} - mul_p_s) : mul_p_s;
    assign prod_lo_s = prod_s[W-1:0];
    assign prod_hi_s = prod_s[2*W-1:W];
    assign mac_sum_s = {1'b0, acc_r} + {1'b0, prod_lo_s};

    seq_multiplier #(.W(W)) u_mul (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .start   (mul_start_s),
        .a       (mul_a_s),
        .b       (mul_b_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .p       (mul_p_s)
    );

    // Next-state, packet shifting, decode and result formation.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        rx_next_s    = rx_r;
        tx_next_s    = tx_r;
        op_next_s    = op_r;
        neg_next_s   = neg_r;
        acc_next_s   = acc_r;
        mul_start_s  = 1'b0;
        mul_a_s      = op_1_s;
        mul_b_s      = op_2_s;
        case (state_r)
            RECEIVE: begin
                cnt_next_s = '0;
                if (!nss_s && mosi_s) begin
                    state_next_s = RECEIVING;
                end else begin
                    state_next_s = RECEIVE;
                end
            end
            RECEIVING: begin
                if (nss_rise_s) begin
                    state_next_s = RECEIVE;
                    cnt_next_s   = '0;
                    rx_next_s    = '0;
                end else begin
                    rx_next_s = {mosi_s, rx_r[RX_BITS-1:1]};
                    if (cnt_r == RX_LAST) begin
                        state_next_s = DECODE;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s = cnt_r + CW'(1);
                    end
                end
            end
            DECODE: begin
                op_next_s  = op_code_s;
                neg_next_s = 1'b0;
                if (!op_valid(op_code_s, ACC_EN != 0)) begin
                    tx_next_s    = {1'b0, 1'b1, {W{1'b0}}};
                    state_next_s = SEND;
                end else if (op_code_s == ACCCLR) begin
                    tx_next_s    = {2'b00, acc_r};
                    acc_next_s   = '0;
                    state_next_s = SEND;
                end else begin
                    mul_start_s  = 1'b1;
                    state_next_s = OPERATE;
                    if (op_code_s == MULH) begin
                        mul_a_s    = magnitude(op_1_s);
                        mul_b_s    = magnitude(op_2_s);
                        neg_next_s = op_1_s[W-1] ^ op_2_s[W-1];
                    end else begin
                        neg_next_s = 1'b0;
                    end
                end
            end
            OPERATE: begin
                if (mul_done_s) begin
                    state_next_s = SEND;
                    case (op_r)
                        MUL:         tx_next_s = {|prod_hi_s, 1'b0, prod_lo_s};
                        MULH, MULHU: tx_next_s = {2'b00, prod_hi_s};
                        MAC: begin
                            acc_next_s = mac_sum_s[W-1:0];
                            tx_next_s  = {mac_sum_s[W] | (|prod_hi_s), 1'b0, mac_sum_s[W-1:0]};
                        end
                        default:     tx_next_s = {1'b0, 1'b1, {W{1'b0}}};
                    endcase
                end else if (!mul_busy_s) begin
                    // Multiplier neither running nor finishing: recover instead of hanging.
                    state_next_s = RECEIVE;
                end else begin
                    state_next_s = OPERATE;
                end
            end
            SEND: begin
                cnt_next_s = '0;
                if (nss_rise_s) begin
                    state_next_s = RECEIVE;
                end else if (!nss_s && !mosi_s) begin
                    state_next_s = SENDING;
                end else begin
                    state_next_s = SEND;
                end
            end
            SENDING: begin
                if (nss_rise_s) begin
                    state_next_s = RECEIVE;
                    cnt_next_s   = '0;
                end else begin
                    tx_next_s = {1'b0, tx_r[TX_BITS-1:1]};
                    if (cnt_r == TX_LAST) begin
                        state_next_s = RECEIVE;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s = cnt_r + CW'(1);
                    end
                end
            end
            default: begin
                state_next_s = RECEIVE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Control and packet registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r <= RECEIVE;
            cnt_r   <= '0;
            rx_r    <= '0;
            tx_r    <= '0;
            op_r    <= '0;
            neg_r   <= 1'b0;
            nss_q_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            rx_r    <= rx_next_s;
            tx_r    <= tx_next_s;
            op_r    <= op_next_s;
            neg_r   <= neg_next_s;
            nss_q_r <= nss_s;
        end
    end

    generate
        if (ACC_EN != 0) begin : g_acc
            // Accumulator for MAC/ACCCLR.
            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) begin
                    acc_r <= '0;
                end else begin
                    acc_r <= acc_next_s;
                end
            end
        end else begin : g_no_acc
            assign acc_r = '0;
        end
    endgenerate

    always_comb begin
        miso_s = 1'b0;
        if (nss_s) begin
            miso_s = 1'b0;
        end else if (state_r == SEND) begin
            miso_s = 1'b1;
        end else if (state_r == SENDING) begin
            miso_s = tx_r[0];
        end else begin
            miso_s = 1'b0;
        end
    end

    assign spi.miso[SLAVE_ID] = miso_s;

endmodule
